fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 34 +++
 rtl/fetch_ctrl_redirect_arb.sv | 47 ++++
 rtl/fetch_ctrl.sv | 150 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch redirect controller.
// Holds the controller state encoding, grant bit positions for the redirect
// arbiter, trap cause constants and the default trap handler entry PC.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_RST = 2'd0,
    ST_RUN      = 2'd1,
    ST_FLUSH    = 2'd2
  } fetch_state_e;

  // One-hot grant vector bit positions, highest priority first.
  localparam int unsigned GNT_W    = 4;
  localparam int unsigned GNT_EXC  = 0;
  localparam int unsigned GNT_IRQ  = 1;
  localparam int unsigned GNT_MRET = 2;
  localparam int unsigned GNT_BR   = 3;

  localparam logic [4:0]  IRQ_EXT_CAUSE    = 5'd11;
  localparam int unsigned MCAUSE_INT_BIT   = 31;
  localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

  // Flush lengths are 1..7, so three bits of down-counter suffice.
  localparam int unsigned FLUSH_CNT_W = 3;

  function automatic logic [31:0] exc_mcause(input logic [4:0] cause);
    return {27'b0, cause};
  endfunction

  function automatic logic [31:0] irq_mcause();
    return (32'd1 << MCAUSE_INT_BIT) | {27'b0, IRQ_EXT_CAUSE};
  endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_arb.sv
// Combinational redirect arbiter.
// Picks one redirect request in fixed priority order
// exception > interrupt > mret > branch and returns a one-hot grant plus the
// matching target PC. Holds no state.
// Ports:
//   exc_valid_i/exc_target_i      exception request and its target
//   irq_eligible_i/irq_target_i   qualified interrupt request and its target
//   mret_valid_i/mret_target_i    trap return request and its target
//   br_valid_i/br_target_i        branch request and its target
//   grant_o                       one-hot grant (zero when nothing requested)
//   target_o                      target PC of the granted request
module redirect_arb
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic             exc_valid_i,
  input  logic [AW-1:0]    exc_target_i,
  input  logic             irq_eligible_i,
  input  logic [AW-1:0]    irq_target_i,
  input  logic             mret_valid_i,
  input  logic [AW-1:0]    mret_target_i,
  input  logic             br_valid_i,
  input  logic [AW-1:0]    br_target_i,
  output logic [GNT_W-1:0] grant_o,
  output logic [AW-1:0]    target_o
);

  always_comb begin
    grant_o  = '0;
    target_o = '0;
    if (exc_valid_i) begin
      grant_o[GNT_EXC] = 1'b1;
      target_o         = exc_target_i;
    end else if (irq_eligible_i) begin
      grant_o[GNT_IRQ] = 1'b1;
      target_o         = irq_target_i;
    end else if (mret_valid_i) begin
      grant_o[GNT_MRET] = 1'b1;
      target_o          = mret_target_i;
    end else if (br_valid_i) begin
      grant_o[GNT_BR] = 1'b1;
      target_o        = br_target_i;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch redirect controller.
// Accepts exception / interrupt / mret / branch redirects while running,
// issues a one-cycle registered jump pulse to the PC generator, flushes the
// front pipeline for FLUSH_CYCLES cycles and tracks the trap registers.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   i_pc_valid                          PC generator active
//   i_stall                             pipeline hold request
//   i_br_valid/i_br_pc                  resolved branch and target
//   i_exc_valid/i_exc_pc/i_exc_cause    synchronous exception
//   i_irq/i_irq_en/i_irq_pc             interrupt level, enable, resume PC
//   i_mret_valid                        return from trap
//   o_jump_valid/o_jump_pc              redirect pulse and target
//   o_holding                           hold request to PC generator
//   o_flush                             kill IF/ID and ID/EX
//   o_mepc/o_mcause/o_in_trap           trap state
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned    AW           = 32,
  parameter logic [AW-1:0]  TRAP_VEC     = AW'(TRAP_VEC_DEFAULT),
  parameter int unsigned    FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_pc_valid,
  input  logic          i_stall,
  input  logic          i_br_valid,
  input  logic [AW-1:0] i_br_pc,
  input  logic          i_exc_valid,
  input  logic [AW-1:0] i_exc_pc,
  input  logic [4:0]    i_exc_cause,
  input  logic          i_irq,
  input  logic          i_irq_en,
  input  logic [AW-1:0] i_irq_pc,
  input  logic          i_mret_valid,
  output logic          o_jump_valid,
  output logic [AW-1:0] o_jump_pc,
  output logic          o_holding,
  output logic          o_flush,
  output logic [AW-1:0] o_mepc,
  output logic [31:0]   o_mcause,
  output logic          o_in_trap
);

  localparam logic [FLUSH_CNT_W-1:0] CNT_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);
  localparam logic [FLUSH_CNT_W-1:0] CNT_ONE  = FLUSH_CNT_W'(1);

  fetch_state_e           state_q;
  logic [FLUSH_CNT_W-1:0] cnt_q;
  logic                   jump_valid_q;
  logic [AW-1:0]          jump_pc_q;
  logic [AW-1:0]          mepc_q, mepc_d;
  logic [31:0]            mcause_q, mcause_d;
  logic                   in_trap_q, in_trap_d;

  logic [GNT_W-1:0]       grant;
  logic [AW-1:0]          target;
  logic                   irq_eligible;
  logic                   accept;

  // Interrupts are masked while a handler is running so the saved PC of the
  // interrupted code is not lost.
  assign irq_eligible = i_irq & i_irq_en & ~in_trap_q;

  redirect_arb #(
    .AW(AW)
  ) u_arb (
    .exc_valid_i   (i_exc_valid),
    .exc_target_i  (TRAP_VEC),
    .irq_eligible_i(irq_eligible),
    .irq_target_i  (TRAP_VEC),
    .mret_valid_i  (i_mret_valid),
    .mret_target_i (mepc_q),
    .br_valid_i    (i_br_valid),
    .br_target_i   (i_br_pc),
    .grant_o       (grant),
    .target_o      (target)
  );

  assign accept = (state_q == ST_RUN) & i_pc_valid & (|grant);

  always_comb begin
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    in_trap_d = in_trap_q;
    if (accept) begin
      if (grant[GNT_EXC]) begin
        mepc_d    = i_exc_pc;
        mcause_d  = exc_mcause(i_exc_cause);
        in_trap_d = 1'b1;
      end else if (grant[GNT_IRQ]) begin
        mepc_d    = i_irq_pc;
        mcause_d  = irq_mcause();
        in_trap_d = 1'b1;
      end else if (grant[GNT_MRET]) begin
        in_trap_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT_RST;
      cnt_q        <= '0;
      jump_valid_q <= 1'b0;
      jump_pc_q    <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      in_trap_q    <= 1'b0;
    end else begin
      jump_valid_q <= 1'b0;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
      in_trap_q    <= in_trap_d;
      // Losing the PC generator overrides every state; trap registers are
      // left untouched so a handler can still be resumed.
      if (!i_pc_valid) begin
        state_q <= ST_WAIT_RST;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          ST_WAIT_RST: state_q <= ST_RUN;
          ST_RUN: begin
            if (accept) begin
              jump_valid_q <= 1'b1;
              jump_pc_q    <= target;
              cnt_q        <= CNT_LOAD;
              state_q      <= ST_FLUSH;
            end
          end
          ST_FLUSH: begin
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_q <= ST_RUN;
          end
          default: state_q <= ST_WAIT_RST;
        endcase
      end
    end
  end

  assign o_jump_valid = jump_valid_q;
  assign o_jump_pc    = jump_pc_q;
  assign o_flush      = (state_q == ST_FLUSH);
  assign o_holding    = i_stall & (state_q == ST_RUN) & ~jump_valid_q;
  assign o_mepc       = mepc_q;
  assign o_mcause     = mcause_q;
  assign o_in_trap    = in_trap_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int unsigned AW = 32;
  localparam int          F  = 2;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_pc_valid = 1'b0, i_stall = 1'b0;
  logic          i_br_valid = 1'b0, i_exc_valid = 1'b0;
  logic [AW-1:0] i_br_pc = '0, i_exc_pc = '0, i_irq_pc = '0;
  logic [4:0]    i_exc_cause = '0;
  logic          i_irq = 1'b0, i_irq_en = 1'b0, i_mret_valid = 1'b0;
  logic          o_jump_valid, o_holding, o_flush, o_in_trap;
  logic [AW-1:0] o_jump_pc, o_mepc;
  logic [31:0]   o_mcause;

  fetch_ctrl #(
    .AW          (AW),
    .TRAP_VEC    (TV),
    .FLUSH_CYCLES(F)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_pc_valid  (i_pc_valid),
    .i_stall     (i_stall),
    .i_br_valid  (i_br_valid),
    .i_br_pc     (i_br_pc),
    .i_exc_valid (i_exc_valid),
    .i_exc_pc    (i_exc_pc),
    .i_exc_cause (i_exc_cause),
    .i_irq       (i_irq),
    .i_irq_en    (i_irq_en),
    .i_irq_pc    (i_irq_pc),
    .i_mret_valid(i_mret_valid),
    .o_jump_valid(o_jump_valid),
    .o_jump_pc   (o_jump_pc),
    .o_holding   (o_holding),
    .o_flush     (o_flush),
    .o_mepc      (o_mepc),
    .o_mcause    (o_mcause),
    .o_in_trap   (o_in_trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pv, st, br, exc, irq, en, mret;
    logic [31:0] brpc, epc, ipc;
    logic [4:0]  cause;
  } stim_t;

  typedef struct {
    bit          jv, fl, hold, trap;
    logic [31:0] mepc, mcause;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] jq[$];
  int          checks = 0;
  int          failures = 0;

  // Reference model: "running" flag, remaining flush cycles, pending pulse.
  bit          m_run, m_pulse, m_trap;
  int          m_left;
  logic [31:0] m_mepc, m_mcause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pulse = 0; m_trap = 0; m_left = 0;
    m_mepc = '0; m_mcause = '0;
  endtask

  function automatic stim_t idle(input bit pv);
    stim_t s;
    s.pv = pv; s.st = 0; s.br = 0; s.exc = 0; s.irq = 0; s.en = 0; s.mret = 0;
    s.brpc = '0; s.epc = '0; s.ipc = '0; s.cause = '0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    exp_t        e;
    bit          take;
    logic [31:0] tgt;
    @(posedge clk);
    #2;
    i_pc_valid = s.pv; i_stall = s.st;
    i_br_valid = s.br; i_br_pc = s.brpc;
    i_exc_valid = s.exc; i_exc_pc = s.epc; i_exc_cause = s.cause;
    i_irq = s.irq; i_irq_en = s.en; i_irq_pc = s.ipc;
    i_mret_valid = s.mret;
    e.jv   = m_pulse;
    e.fl   = (m_left > 0);
    e.hold = s.st && m_run && (m_left == 0) && !m_pulse;
    e.mepc = m_mepc; e.mcause = m_mcause; e.trap = m_trap;
    exp_q.push_back(e);
    m_pulse = 0;
    tgt = '0;
    if (!s.pv) begin
      m_run = 0; m_left = 0;
    end else if (!m_run) begin
      m_run = 1;
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      take = 1;
      if (s.exc) begin
        m_mepc = s.epc; m_mcause = {27'b0, s.cause}; m_trap = 1; tgt = TV;
      end else if (s.irq && s.en && !m_trap) begin
        m_mepc = s.ipc; m_mcause = 32'h8000_000B; m_trap = 1; tgt = TV;
      end else if (s.mret) begin
        tgt = m_mepc; m_trap = 0;
      end else if (s.br) begin
        tgt = s.brpc;
      end else begin
        take = 0;
      end
      if (take) begin
        m_pulse = 1; m_left = F; jq.push_back(tgt);
      end
    end
  endtask

  task automatic check_all_zero();
    chk("rst_jump_valid", {31'b0, o_jump_valid}, 0);
    chk("rst_jump_pc", o_jump_pc, 0);
    chk("rst_flush", {31'b0, o_flush}, 0);
    chk("rst_holding", {31'b0, o_holding}, 0);
    chk("rst_mepc", o_mepc, 0);
    chk("rst_mcause", o_mcause, 0);
    chk("rst_in_trap", {31'b0, o_in_trap}, 0);
  endtask

  // Asserted mid-cycle so the asynchronous effect is visible before any edge.
  task automatic do_reset(input int hold);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    i_pc_valid = 1'b0; i_stall = 1'b1;
    i_br_valid = 1'b0; i_exc_valid = 1'b0; i_irq = 1'b0; i_mret_valid = 1'b0;
    #1;
    check_all_zero();
    exp_q.delete();
    jq.delete();
    model_reset();
    repeat (hold) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: one expected record per driven cycle, jump targets from jq.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("jump_valid", {31'b0, o_jump_valid}, {31'b0, e.jv});
        chk("flush", {31'b0, o_flush}, {31'b0, e.fl});
        chk("holding", {31'b0, o_holding}, {31'b0, e.hold});
        chk("mepc", o_mepc, e.mepc);
        chk("mcause", o_mcause, e.mcause);
        chk("in_trap", {31'b0, o_in_trap}, {31'b0, e.trap});
        if (o_jump_valid) begin
          if (jq.size() > 0) begin
            chk("jump_pc", o_jump_pc, jq.pop_front());
          end else begin
            checks++;
            failures++;
            $display("FAIL jump_unexpected: got pulse pc %0h expected no pulse", o_jump_pc);
          end
        end
      end
    end
  end

  initial begin
    stim_t s;
    bit    irq_lvl;
    model_reset();
    #1;
    check_all_zero();
    do_reset(3);

    // Start-up: 8 idle cycles in WAIT_RST with stall, then PC valid.
    s = idle(0); s.st = 1;
    repeat (8) drive(s);
    s.pv = 1;
    repeat (3) drive(s);

    // Branch to 0x40; a branch during the first flush cycle is ignored.
    s = idle(1); s.br = 1; s.brpc = 32'h40;
    drive(s);
    s.brpc = 32'h80;
    drive(s);
    s = idle(1);
    repeat (4) drive(s);

    // Exception + branch + interrupt in one cycle: exception wins.
    s = idle(1);
    s.exc = 1; s.epc = 32'h20; s.cause = 5'd2;
    s.br = 1; s.brpc = 32'h80;
    s.irq = 1; s.en = 1; s.ipc = 32'h54;
    drive(s);
    s = idle(1);
    repeat (4) drive(s);
    s.mret = 1;
    drive(s);
    s = idle(1);
    repeat (4) drive(s);

    // Interrupt, ignored while in trap, then mret back to 0x54.
    s = idle(1); s.irq = 1; s.en = 1; s.ipc = 32'h54;
    drive(s);
    s.ipc = 32'h99C;
    repeat (5) drive(s);
    s.mret = 1;
    drive(s);
    s = idle(1);
    repeat (4) drive(s);

    // Stall holds; a branch under stall still redirects.
    s = idle(1); s.st = 1;
    repeat (2) drive(s);
    s.br = 1; s.brpc = 32'h60;
    drive(s);
    s.br = 0;
    repeat (4) drive(s);

    // Reset during the first flush cycle.
    s = idle(1); s.br = 1; s.brpc = 32'h70;
    drive(s);
    do_reset(2);
    s = idle(0);
    drive(s);
    s = idle(1);
    repeat (4) drive(s);

    // Randomised traffic.
    irq_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        if ($urandom_range(0, 9) == 0) irq_lvl = ~irq_lvl;
        s.pv    = ($urandom_range(0, 19) != 0);
        s.st    = ($urandom_range(0, 9) < 3);
        s.br    = ($urandom_range(0, 3) == 0);
        s.exc   = ($urandom_range(0, 11) == 0);
        s.mret  = ($urandom_range(0, 6) == 0);
        s.irq   = irq_lvl;
        s.en    = ($urandom_range(0, 9) < 7);
        s.brpc  = $urandom & 32'hFFFF_FFFC;
        s.epc   = $urandom & 32'hFFFF_FFFC;
        s.ipc   = $urandom & 32'hFFFF_FFFC;
        s.cause = 5'($urandom_range(0, 31));
        drive(s);
      end
    end

    repeat (3) @(posedge clk);
    chk("jump_queue_drained", jq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
